// File: rtl/vga_out_pkg.sv
// vga_out_pkg
//   Shared constants for the VGA output stage.
//   - BAYER_2X2  : 2x2 ordered-dither levels, indexed by {py,px} -> {0,2,3,1}
//   - DSHIFT     : threshold scale exponent for the default widths
//   - OUT_W_ZX1 / OUT_W_NZX1 : per-build default output widths
//   - bayer_lvl(): look up the unscaled dither level for a phase index
package vga_out_pkg;

  localparam int IN_W_DEF   = 8;
  localparam int OUT_W_ZX1  = 3;
  localparam int OUT_W_NZX1 = 6;
  localparam int DSHIFT     = IN_W_DEF - OUT_W_ZX1 - 2;

  // Packed so that entry i lives in bits [2*i +: 2]: idx0=0, idx1=2, idx2=3, idx3=1.
  localparam logic [7:0] BAYER_2X2 = {2'd1, 2'd3, 2'd2, 2'd0};

  function automatic logic [1:0] bayer_lvl(input logic [1:0] idx);
    bayer_lvl = BAYER_2X2[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/dither_channel.sv
// dither_channel
//   One colour channel of the output ditherer: add threshold, saturate,
//   truncate to OUT_W bits, and force black while DE is low.
//   Ports:
//     pix_i [IN_W]  colour sample (S1 register)
//     thr_i [IN_W]  already-scaled threshold (0 when dithering is off)
//     de_i          delayed DE; 0 blanks the output
//     val_o [OUT_W] reduced colour (registered by the caller)
module dither_channel
  import vga_out_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_ZX1
) (
  input  logic [IN_W-1:0]  pix_i,
  input  logic [IN_W-1:0]  thr_i,
  input  logic             de_i,
  output logic [OUT_W-1:0] val_o
);

  logic [IN_W:0]   sum_s;
  logic [IN_W-1:0] sat_s;

  // Add with carry, clamp on overflow, keep the top OUT_W bits, blank outside DE.
  always_comb begin
    sum_s = {1'b0, pix_i} + {1'b0, thr_i};
    if (sum_s[IN_W]) begin
      sat_s = {IN_W{1'b1}};
    end else begin
      sat_s = sum_s[IN_W-1:0];
    end
    if (de_i) begin
      val_o = sat_s[IN_W-1 -: OUT_W];
    end else begin
      val_o = {OUT_W{1'b0}};
    end
  end

endmodule

// File: rtl/vga_dither_out.sv
// vga_dither_out
//   Final VGA output stage: 2x2 ordered dithering of 8-bit R/G/B down to
//   OUT_W bits per channel, optional frame-alternating matrix phase, and
//   sync/DE delayed to match the two-stage colour pipeline.
//   Ports:
//     CLK_VIDEO, reset         video clock, synchronous active-high reset
//     ce_pix                   pixel enable; all state advances only on it
//     r_in/g_in/b_in [IN_W]    colour after OSD overlay
//     hs_in/vs_in/de_in        positive syncs and active-video enable
//     dither_en                0 = plain truncation
//     temporal_en              1 = invert matrix phase on odd frames
//     r_out/g_out/b_out [OUT_W] dithered colour (2 enables latency)
//     hs_out/vs_out/de_out     syncs/DE delayed by 2 enables
//     ce_out                   ce_pix delayed one clock
module vga_dither_out
  import vga_out_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_ZX1
) (
  input  logic             CLK_VIDEO,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic [IN_W-1:0]  r_in,
  input  logic [IN_W-1:0]  g_in,
  input  logic [IN_W-1:0]  b_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             de_in,
  input  logic             dither_en,
  input  logic             temporal_en,
  output logic [OUT_W-1:0] r_out,
  output logic [OUT_W-1:0] g_out,
  output logic [OUT_W-1:0] b_out,
  output logic             hs_out,
  output logic             vs_out,
  output logic             de_out,
  output logic             ce_out
);

  localparam int THR_SHIFT = IN_W - OUT_W - 2;

  // Phase and edge-detect state
  logic hs_prev_q, vs_prev_q, de_prev_q;
  logic xp_q, yp_q, fp_q;
  logic xp_d, yp_d, fp_d;

  // Stage 1
  logic [IN_W-1:0] r_s1_q, g_s1_q, b_s1_q, thr_s1_q;
  logic            hs_s1_q, vs_s1_q, de_s1_q;

  // Stage 2 / outputs
  logic [OUT_W-1:0] r_q, g_q, b_q;
  logic             hs_q, vs_q, de_q, ce_q;

  // Combinational
  logic             de_rise_s, hs_rise_s, vs_rise_s;
  logic             xp_cur_s, px_s, py_s, tflip_s;
  logic [IN_W-1:0]  thr_s;
  logic [OUT_W-1:0] r_s, g_s, b_s;

  // Next phase values and the threshold for the pixel presented this enable.
  // The current pixel uses the already-updated y/f parities and an x parity
  // that is forced to 0 on the first pixel of a DE run.
  always_comb begin
    de_rise_s = de_in & ~de_prev_q;
    hs_rise_s = hs_in & ~hs_prev_q;
    vs_rise_s = vs_in & ~vs_prev_q;

    fp_d = fp_q ^ vs_rise_s;

    // A frame start overrides a coincident line start.
    if (vs_rise_s) begin
      yp_d = 1'b0;
    end else if (hs_rise_s) begin
      yp_d = ~yp_q;
    end else begin
      yp_d = yp_q;
    end

    if (de_rise_s) begin
      xp_cur_s = 1'b0;
    end else begin
      xp_cur_s = xp_q;
    end

    if (de_in) begin
      xp_d = ~xp_cur_s;
    end else begin
      xp_d = xp_q;
    end

    tflip_s = temporal_en & fp_d;
    px_s    = xp_cur_s ^ tflip_s;
    py_s    = yp_d ^ tflip_s;

    if (dither_en) begin
      thr_s = {{(IN_W-2){1'b0}}, bayer_lvl({py_s, px_s})} << THR_SHIFT;
    end else begin
      thr_s = {IN_W{1'b0}};
    end
  end

  dither_channel #(.IN_W(IN_W), .OUT_W(OUT_W)) u_ch_r (
    .pix_i (r_s1_q),
    .thr_i (thr_s1_q),
    .de_i  (de_s1_q),
    .val_o (r_s)
  );

  dither_channel #(.IN_W(IN_W), .OUT_W(OUT_W)) u_ch_g (
    .pix_i (g_s1_q),
    .thr_i (thr_s1_q),
    .de_i  (de_s1_q),
    .val_o (g_s)
  );

  dither_channel #(.IN_W(IN_W), .OUT_W(OUT_W)) u_ch_b (
    .pix_i (b_s1_q),
    .thr_i (thr_s1_q),
    .de_i  (de_s1_q),
    .val_o (b_s)
  );

  // Phase tracking plus the two pipeline stages, all gated by ce_pix.
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      de_prev_q <= 1'b0;
      xp_q      <= 1'b0;
      yp_q      <= 1'b0;
      fp_q      <= 1'b0;
      r_s1_q    <= {IN_W{1'b0}};
      g_s1_q    <= {IN_W{1'b0}};
      b_s1_q    <= {IN_W{1'b0}};
      thr_s1_q  <= {IN_W{1'b0}};
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      de_s1_q   <= 1'b0;
      r_q       <= {OUT_W{1'b0}};
      g_q       <= {OUT_W{1'b0}};
      b_q       <= {OUT_W{1'b0}};
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
    end else if (ce_pix) begin
      hs_prev_q <= hs_in;
      vs_prev_q <= vs_in;
      de_prev_q <= de_in;
      xp_q      <= xp_d;
      yp_q      <= yp_d;
      fp_q      <= fp_d;
      r_s1_q    <= r_in;
      g_s1_q    <= g_in;
      b_s1_q    <= b_in;
      thr_s1_q  <= thr_s;
      hs_s1_q   <= hs_in;
      vs_s1_q   <= vs_in;
      de_s1_q   <= de_in;
      r_q       <= r_s;
      g_q       <= g_s;
      b_q       <= b_s;
      hs_q      <= hs_s1_q;
      vs_q      <= vs_s1_q;
      de_q      <= de_s1_q;
    end else begin
      hs_prev_q <= hs_prev_q;
      vs_prev_q <= vs_prev_q;
      de_prev_q <= de_prev_q;
      xp_q      <= xp_q;
      yp_q      <= yp_q;
      fp_q      <= fp_q;
      r_s1_q    <= r_s1_q;
      g_s1_q    <= g_s1_q;
      b_s1_q    <= b_s1_q;
      thr_s1_q  <= thr_s1_q;
      hs_s1_q   <= hs_s1_q;
      vs_s1_q   <= vs_s1_q;
      de_s1_q   <= de_s1_q;
      r_q       <= r_q;
      g_q       <= g_q;
      b_q       <= b_q;
      hs_q      <= hs_q;
      vs_q      <= vs_q;
      de_q      <= de_q;
    end
  end

  // Pixel-enable echo so downstream samples S2 one clock after it settles.
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      ce_q <= 1'b0;
    end else begin
      ce_q <= ce_pix;
    end
  end

  assign r_out  = r_q;
  assign g_out  = g_q;
  assign b_out  = b_q;
  assign hs_out = hs_q;
  assign vs_out = vs_q;
  assign de_out = de_q;
  assign ce_out = ce_q;

endmodule

// File: tb/tb_vga_dither_out.sv
// tb_vga_dither_out
//   Scoreboard bench for vga_dither_out: the driver pushes the expected
//   {r,g,b,hs,vs,de} for every pixel enable; a monitor pops and compares on
//   every ce_out, and checks that outputs hold steady between enables.
module tb_vga_dither_out;

  logic       CLK_VIDEO = 1'b0;
  logic       reset = 1'b1;
  logic       ce_pix = 1'b0;
  logic [7:0] r_in = 8'd0, g_in = 8'd0, b_in = 8'd0;
  logic       hs_in = 1'b0, vs_in = 1'b0, de_in = 1'b0;
  logic       dither_en = 1'b0, temporal_en = 1'b0;
  logic [2:0] r_out, g_out, b_out;
  logic       hs_out, vs_out, de_out, ce_out;

  vga_dither_out #(.IN_W(8), .OUT_W(3)) dut (
    .CLK_VIDEO   (CLK_VIDEO),
    .reset       (reset),
    .ce_pix      (ce_pix),
    .r_in        (r_in),
    .g_in        (g_in),
    .b_in        (b_in),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .de_in       (de_in),
    .dither_en   (dither_en),
    .temporal_en (temporal_en),
    .r_out       (r_out),
    .g_out       (g_out),
    .b_out       (b_out),
    .hs_out      (hs_out),
    .vs_out      (vs_out),
    .de_out      (de_out),
    .ce_out      (ce_out)
  );

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_got, mon_exp, snap;
  logic        rst_at_edge = 1'b1;

  // Reference phase state
  logic m_xp = 1'b0, m_yp = 1'b0, m_fp = 1'b0;
  logic m_hs = 1'b0, m_vs = 1'b0, m_de = 1'b0;

  function automatic int thr_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return 0;
      2'd1:    return 16;
      2'd2:    return 24;
      default: return 8;
    endcase
  endfunction

  function automatic logic [2:0] chan_exp(input int c, input int thr, input logic de);
    int s;
    s = c + thr;
    if (s > 255) s = 255;
    if (!de) return 3'd0;
    return 3'(s / 32);
  endfunction

  task automatic model_reset();
    m_xp = 1'b0; m_yp = 1'b0; m_fp = 1'b0;
    m_hs = 1'b0; m_vs = 1'b0; m_de = 1'b0;
  endtask

  task automatic model_push(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic hs, input logic vs, input logic de);
    logic dr, hr, vr, xu, px, py;
    int   thr;
    dr = de & ~m_de;
    hr = hs & ~m_hs;
    vr = vs & ~m_vs;
    m_fp = m_fp ^ vr;
    if (vr) m_yp = 1'b0;
    else if (hr) m_yp = ~m_yp;
    xu = dr ? 1'b0 : m_xp;
    px = xu ^ (temporal_en & m_fp);
    py = m_yp ^ (temporal_en & m_fp);
    thr = dither_en ? thr_of({py, px}) : 0;
    exp_q.push_back({chan_exp(int'(r), thr, de), chan_exp(int'(g), thr, de),
                     chan_exp(int'(b), thr, de), hs, vs, de});
    if (de) m_xp = ~xu;
    m_hs = hs; m_vs = vs; m_de = de;
  endtask

  // One pixel enable followed by one idle clock.
  task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic hs, input logic vs, input logic de);
    @(negedge CLK_VIDEO);
    r_in = r; g_in = g; b_in = b;
    hs_in = hs; vs_in = vs; de_in = de;
    ce_pix = 1'b1;
    model_push(r, g, b, hs, vs, de);
    @(negedge CLK_VIDEO);
    ce_pix = 1'b0;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) pix(8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hsync();
    pix(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    logic [12:0] got;
    got = {r_out, g_out, b_out, hs_out, vs_out, de_out, ce_out};
    n_cmp++;
    if (got !== 13'd0) begin
      n_bad++;
      $display("FAIL %s: outputs got %h want 0000", tag, got);
    end
  endtask

  always @(posedge CLK_VIDEO) rst_at_edge = reset;

  // Monitor: score every ce_out, and require stable outputs otherwise.
  always @(negedge CLK_VIDEO) begin
    mon_got = {r_out, g_out, b_out, hs_out, vs_out, de_out};
    if (ce_out === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_underflow: ce_out with no expected entry, got %h", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_bad++;
          $display("FAIL pixel @%0t: got r%0d g%0d b%0d hs%b vs%b de%b want r%0d g%0d b%0d hs%b vs%b de%b",
                   $time, mon_got[11:9], mon_got[8:6], mon_got[5:3], mon_got[2], mon_got[1], mon_got[0],
                   mon_exp[11:9], mon_exp[8:6], mon_exp[5:3], mon_exp[2], mon_exp[1], mon_exp[0]);
        end
      end
    end else if (!rst_at_edge) begin
      n_cmp++;
      if (mon_got !== snap) begin
        n_bad++;
        $display("FAIL hold @%0t: got %h want %h", $time, mon_got, snap);
      end
    end
    snap = mon_got;
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: run did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    // Reset state
    repeat (2) @(posedge CLK_VIDEO);
    #1;
    check_all_zero("reset_state");
    @(negedge CLK_VIDEO);
    reset = 1'b0;
    model_reset();
    exp_q.push_back(12'd0);

    // Phase pattern: line 0 then line 1, r constant 0x30
    dither_en = 1'b1; temporal_en = 1'b0;
    pix(8'h30, 8'h10, 8'h80, 1'b0, 1'b0, 1'b1);
    pix(8'h30, 8'h50, 8'h81, 1'b0, 1'b0, 1'b1);
    pix(8'h30, 8'h90, 8'h82, 1'b0, 1'b0, 1'b1);
    pix(8'h30, 8'hD0, 8'h83, 1'b0, 1'b0, 1'b1);
    blank(2);
    hsync();
    // Line 1 also exercises saturation: g 0xF0 at phase {1,0}, b 0xFF
    pix(8'h30, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b1);
    pix(8'h30, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
    pix(8'h30, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b1);
    pix(8'h30, 8'h7F, 8'hFF, 1'b0, 1'b0, 1'b1);
    blank(2);

    // Truncation
    hsync();
    dither_en = 1'b0;
    pix(8'h30, 8'h30, 8'h1F, 1'b0, 1'b0, 1'b1);
    pix(8'h1F, 8'h30, 8'h30, 1'b0, 1'b0, 1'b1);
    pix(8'h30, 8'h1F, 8'hE0, 1'b0, 1'b0, 1'b1);
    pix(8'h30, 8'h30, 8'hFF, 1'b0, 1'b0, 1'b1);
    blank(2);

    // Temporal: simultaneous hs/vs rise, two lines, then a new frame
    dither_en = 1'b1; temporal_en = 1'b1;
    pix(8'h00, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0);
    pix(8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pix(8'h30, 8'h30, 8'h30, 1'b0, 1'b0, 1'b1);
    blank(1);
    hsync();
    for (int i = 0; i < 4; i++) pix(8'h30, 8'h30, 8'h30, 1'b0, 1'b0, 1'b1);
    blank(1);
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pix(8'h30, 8'hF0, 8'h08, 1'b0, 1'b0, 1'b1);
    blank(1);
    temporal_en = 1'b0;

    // Reset mid-line, with DE held high across it
    hsync();
    pix(8'h30, 8'h30, 8'h30, 1'b0, 1'b0, 1'b1);
    pix(8'h30, 8'h30, 8'h30, 1'b0, 1'b0, 1'b1);
    @(negedge CLK_VIDEO);
    reset = 1'b1;
    exp_q.delete();
    model_reset();
    @(posedge CLK_VIDEO);
    #1;
    check_all_zero("reset_midline");
    @(negedge CLK_VIDEO);
    reset = 1'b0;
    exp_q.push_back(12'd0);
    for (int i = 0; i < 4; i++) pix(8'h30, 8'h30, 8'h30, 1'b0, 1'b0, 1'b1);
    blank(3);

    // Exactly the last issued pixel should still be in flight
    repeat (4) @(negedge CLK_VIDEO);
    n_cmp++;
    if (exp_q.size() != 1) begin
      n_bad++;
      $display("FAIL sb_drain: pending entries got %0d want 1", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
